// File: rtl/mem_controller_pkg.sv
// rtl/mem_controller_pkg.sv - shared state codes, encodings and byte-lane helpers for mem_controller
//
// Purpose: definitions used by mem_controller and by the LSB/IFetch requesters.
// Ports: none (package).
package mem_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READING = 2'd1,
    WRITING = 2'd2,
    DONE    = 2'd3
  } state_e;

  // mem_data_width encoding
  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  // addr[17:16] value that selects the IO space
  localparam logic [1:0] IO_SEL = 2'b11;

  // mem_query_type encoding, shared with the LSB
  localparam logic QUERY_READ  = 1'b0;
  localparam logic QUERY_WRITE = 1'b1;

  // Which requester owns the access in flight
  localparam logic PORT_DATA  = 1'b0;
  localparam logic PORT_FETCH = 1'b1;

  // Byte count of an access; the unused code 3 is treated as a word.
  function automatic logic [2:0] width_to_bytes(input logic [1:0] w);
    case (w)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      WIDTH_WORD: return 3'd4;
      default:    return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - byte-serialising RAM/IO controller for the LSB and IFetch query ports
//
// Purpose: accepts one read/write request at a time (data port over fetch port),
// drives the byte-wide RAM bus and returns a one-cycle reply pulse.
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (low = hold everything)
//   io_buffer_full                       : IO writes must wait while high
//   mem_din / mem_dout / mem_a / mem_wr  : external byte bus, read data one cycle late
//   mem_query_* / mem_reply_*            : LSB request and reply
//   if_query_* / if_reply_*              : instruction fetch request and reply (always 4 bytes)
//   flush_signal                         : aborts reads, silences replies of in-flight writes
module mem_controller
  import mem_controller_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        mem_query_en,
  input  logic        mem_query_type,
  input  logic [31:0] mem_query_addr,
  input  logic [1:0]  mem_data_width,
  input  logic [31:0] mem_query_data,
  output logic        mem_reply_en,
  output logic [31:0] mem_reply_data,
  input  logic        if_query_en,
  input  logic [31:0] if_query_addr,
  output logic        if_reply_en,
  output logic [31:0] if_reply_data,
  input  logic        flush_signal
);

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  n_q, n_d;
  // Reads: edges spent in READING. Writes: index of next byte to issue.
  logic [2:0]  cnt_q, cnt_d;
  // Store data for writes, partially assembled result for reads
  logic [31:0] data_q, data_d;
  logic        flushed_q, flushed_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_reply_en_q, mem_reply_en_d;
  logic [31:0] mem_reply_data_q, mem_reply_data_d;
  logic        if_reply_en_q, if_reply_en_d;
  logic [31:0] if_reply_data_q, if_reply_data_d;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q          <= IDLE;
      port_q           <= PORT_DATA;
      addr_q           <= '0;
      n_q              <= '0;
      cnt_q            <= '0;
      data_q           <= '0;
      flushed_q        <= 1'b0;
      mem_a_q          <= '0;
      mem_dout_q       <= '0;
      mem_wr_q         <= 1'b0;
      mem_reply_en_q   <= 1'b0;
      mem_reply_data_q <= '0;
      if_reply_en_q    <= 1'b0;
      if_reply_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      port_q           <= port_d;
      addr_q           <= addr_d;
      n_q              <= n_d;
      cnt_q            <= cnt_d;
      data_q           <= data_d;
      flushed_q        <= flushed_d;
      mem_a_q          <= mem_a_d;
      mem_dout_q       <= mem_dout_d;
      mem_wr_q         <= mem_wr_d;
      mem_reply_en_q   <= mem_reply_en_d;
      mem_reply_data_q <= mem_reply_data_d;
      if_reply_en_q    <= if_reply_en_d;
      if_reply_data_q  <= if_reply_data_d;
    end
  end

  always_comb begin
    logic [31:0] addr_sel;
    logic [31:0] wr_addr;
    logic [31:0] word;
    addr_sel         = mem_query_en ? mem_query_addr : if_query_addr;
    wr_addr          = addr_q + 32'(cnt_q);
    word             = put_byte(data_q, cnt_q[1:0] - 2'd1, mem_din);
    state_d          = state_q;
    port_d           = port_q;
    addr_d           = addr_q;
    n_d              = n_q;
    cnt_d            = cnt_q;
    data_d           = data_q;
    flushed_d        = flushed_q;
    mem_a_d          = mem_a_q;
    mem_dout_d       = mem_dout_q;
    mem_wr_d         = mem_wr_q;
    mem_reply_en_d   = mem_reply_en_q;
    mem_reply_data_d = mem_reply_data_q;
    if_reply_en_d    = if_reply_en_q;
    if_reply_data_d  = if_reply_data_q;

    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (!flush_signal && (mem_query_en || if_query_en)) begin
            port_d    = mem_query_en ? PORT_DATA : PORT_FETCH;
            addr_d    = addr_sel;
            n_d       = mem_query_en ? width_to_bytes(mem_data_width) : 3'd4;
            cnt_d     = 3'd0;
            flushed_d = 1'b0;
            mem_a_d   = addr_sel;
            if (mem_query_en && mem_query_type == QUERY_WRITE) begin
              data_d  = mem_query_data;
              state_d = WRITING;
              // Byte 0 goes out right away unless the IO sink is full.
              if (is_io(addr_sel) && io_buffer_full) begin
                mem_wr_d = 1'b0;
              end else begin
                mem_wr_d   = 1'b1;
                mem_dout_d = mem_query_data[7:0];
                cnt_d      = 3'd1;
              end
            end else begin
              data_d   = '0;
              mem_wr_d = 1'b0;
              state_d  = READING;
            end
          end
        end

        READING: begin
          if (flush_signal) begin
            state_d        = IDLE;
            mem_a_d        = '0;
            mem_wr_d       = 1'b0;
            mem_reply_en_d = 1'b0;
            if_reply_en_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 3'd1;
            // Address of byte cnt+1 goes out while byte cnt-1 comes back.
            if (cnt_q + 3'd1 < n_q) mem_a_d = addr_q + 32'(cnt_q) + 32'd1;
            if (cnt_q != 3'd0) begin
              data_d = word;
              if (cnt_q == n_q) begin
                state_d = DONE;
                mem_a_d = '0;
                if (port_q == PORT_DATA) begin
                  mem_reply_en_d   = 1'b1;
                  mem_reply_data_d = word;
                end else begin
                  if_reply_en_d   = 1'b1;
                  if_reply_data_d = word;
                end
              end
            end
          end
        end

        WRITING: begin
          // A started store is committed; a flush only silences its reply.
          if (flush_signal) flushed_d = 1'b1;
          if (cnt_q == n_q) begin
            state_d    = DONE;
            mem_wr_d   = 1'b0;
            mem_a_d    = '0;
            mem_dout_d = '0;
            if (!(flushed_q || flush_signal)) mem_reply_en_d = 1'b1;
          end else begin
            mem_a_d = wr_addr;
            if (is_io(wr_addr) && io_buffer_full) begin
              mem_wr_d = 1'b0;
            end else begin
              mem_wr_d   = 1'b1;
              mem_dout_d = get_byte(data_q, cnt_q[1:0]);
              cnt_d      = cnt_q + 3'd1;
            end
          end
        end

        DONE: begin
          // Requests are ignored here so a requester that drops its request
          // one cycle after the reply is not served twice.
          state_d        = IDLE;
          mem_a_d        = '0;
          mem_wr_d       = 1'b0;
          mem_reply_en_d = 1'b0;
          if_reply_en_d  = 1'b0;
        end

        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_a          = mem_a_q;
  assign mem_dout       = mem_dout_q;
  assign mem_wr         = mem_wr_q;
  assign mem_reply_en   = mem_reply_en_q;
  assign mem_reply_data = mem_reply_data_q;
  assign if_reply_en    = if_reply_en_q;
  assign if_reply_data  = if_reply_data_q;

endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed self-checking bench for mem_controller
module tb_mem_controller;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        io_buffer_full;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        mem_query_en;
  logic        mem_query_type;
  logic [31:0] mem_query_addr;
  logic [1:0]  mem_data_width;
  logic [31:0] mem_query_data;
  logic        mem_reply_en;
  logic [31:0] mem_reply_data;
  logic        if_query_en;
  logic [31:0] if_query_addr;
  logic        if_reply_en;
  logic [31:0] if_reply_data;
  logic        flush_signal;

  int checks = 0;
  int failures = 0;
  int mem_reply_cnt = 0;
  int if_reply_cnt = 0;
  logic [31:0] wr_a[$];
  logic [7:0]  wr_d[$];

  mem_controller dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_query_en   (mem_query_en),
    .mem_query_type (mem_query_type),
    .mem_query_addr (mem_query_addr),
    .mem_data_width (mem_data_width),
    .mem_query_data (mem_query_data),
    .mem_reply_en   (mem_reply_en),
    .mem_reply_data (mem_reply_data),
    .if_query_en    (if_query_en),
    .if_query_addr  (if_query_addr),
    .if_reply_en    (if_reply_en),
    .if_reply_data  (if_reply_data),
    .flush_signal   (flush_signal)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h13;
      32'h1:   return 8'h00;
      32'h2:   return 8'h00;
      32'h3:   return 8'h00;
      32'h100: return 8'h11;
      32'h101: return 8'h22;
      32'h102: return 8'h33;
      32'h103: return 8'h44;
      default: return a[7:0] ^ 8'hA5;
    endcase
  endfunction

  // Byte-wide memory: read data one cycle after the address, paused with the core.
  always @(posedge clk_in) begin
    if (rdy_in) begin
      if (mem_wr) begin
        wr_a.push_back(mem_a);
        wr_d.push_back(mem_dout);
      end
      mem_din <= rom(mem_a);
    end
    if (mem_reply_en) mem_reply_cnt <= mem_reply_cnt + 1;
    if (if_reply_en)  if_reply_cnt  <= if_reply_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive a data-port request now; returns just after the accept edge (cycle 0).
  task automatic start_mem(input logic typ, input logic [31:0] addr, input logic [1:0] w,
                           input logic [31:0] data);
    mem_query_en   = 1'b1;
    mem_query_type = typ;
    mem_query_addr = addr;
    mem_data_width = w;
    mem_query_data = data;
    tick();
  endtask

  task automatic wait_reply(input bit fetch, input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (fetch ? if_reply_en : mem_reply_en) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int base;
    int mcnt;
    int icnt;
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; flush_signal = 1'b0;
    mem_query_en = 1'b0; mem_query_type = 1'b0; mem_query_addr = '0;
    mem_data_width = 2'd0; mem_query_data = '0; if_query_en = 1'b0; if_query_addr = '0;
    tick(); tick();
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_reply_en", 32'({mem_reply_en, if_reply_en}), 32'h0);
    check("rst_reply_data", mem_reply_data | if_reply_data, 32'h0);
    rst_in = 1'b1;
    tick();

    // lw at 0x100
    start_mem(1'b0, 32'h100, 2'd2, 32'h0);
    check("lw_c0_addr", mem_a, 32'h100);
    check("lw_c0_wr", 32'(mem_wr), 32'h0);
    wait_reply(1'b0, 20, lat);
    check("lw_latency", 32'(lat), 32'd5);
    check("lw_data", mem_reply_data, 32'h44332211);
    mem_query_en = 1'b0;
    tick();
    check("lw_pulse_len", 32'(mem_reply_en), 32'h0);
    check("lw_idle_addr", mem_a, 32'h0);

    // sh at 0x200
    base = wr_a.size();
    start_mem(1'b1, 32'h200, 2'd1, 32'hDEADBEEF);
    check("sh_c0_wr", 32'(mem_wr), 32'h1);
    check("sh_c0_dout", 32'(mem_dout), 32'hEF);
    wait_reply(1'b0, 20, lat);
    check("sh_latency", 32'(lat), 32'd2);
    mem_query_en = 1'b0;
    tick();
    check("sh_nwrites", 32'(wr_a.size() - base), 32'd2);
    if (wr_a.size() >= base + 2) begin
      check("sh_a0", wr_a[base], 32'h200);
      check("sh_d0", 32'(wr_d[base]), 32'hEF);
      check("sh_a1", wr_a[base+1], 32'h201);
      check("sh_d1", 32'(wr_d[base+1]), 32'hBE);
    end

    // simultaneous data read (lh 0x102) and fetch (0x0)
    mcnt = mem_reply_cnt; icnt = if_reply_cnt;
    if_query_en = 1'b1; if_query_addr = 32'h0;
    start_mem(1'b0, 32'h102, 2'd1, 32'h0);
    check("both_c0_addr", mem_a, 32'h102);
    wait_reply(1'b0, 20, lat);
    check("both_data_latency", 32'(lat), 32'd3);
    check("both_data", mem_reply_data, 32'h00004433);
    check("both_no_if_yet", 32'(if_reply_en), 32'h0);
    mem_query_en = 1'b0;
    wait_reply(1'b1, 20, lat);
    check("both_fetch_latency", 32'(lat), 32'd7);
    check("both_fetch_data", if_reply_data, 32'h00000013);
    if_query_en = 1'b0;
    tick(); tick(); tick();
    check("both_mem_replies", 32'(mem_reply_cnt - mcnt), 32'd1);
    check("both_if_replies", 32'(if_reply_cnt - icnt), 32'd1);

    // sb to IO with the buffer full for 3 cycles
    base = wr_a.size();
    io_buffer_full = 1'b1;
    start_mem(1'b1, 32'h30000, 2'd0, 32'h1234565A);
    check("io_c0_wr", 32'(mem_wr), 32'h0);
    tick();
    check("io_c1_wr", 32'(mem_wr), 32'h0);
    tick();
    check("io_c2_wr", 32'(mem_wr), 32'h0);
    io_buffer_full = 1'b0;
    tick();
    check("io_c3_wr", 32'(mem_wr), 32'h1);
    check("io_c3_addr", mem_a, 32'h30000);
    check("io_c3_dout", 32'(mem_dout), 32'h5A);
    tick();
    check("io_c4_reply", 32'(mem_reply_en), 32'h1);
    mem_query_en = 1'b0;
    tick();
    check("io_nwrites", 32'(wr_a.size() - base), 32'd1);

    // flush during cycle 2 of a fetch
    icnt = if_reply_cnt;
    if_query_en = 1'b1; if_query_addr = 32'h0;
    tick(); tick(); tick();
    flush_signal = 1'b1;
    tick();
    check("fflush_idle_addr", mem_a, 32'h0);
    check("fflush_reply", 32'(if_reply_en), 32'h0);
    flush_signal = 1'b0; if_query_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("fflush_no_reply", 32'(if_reply_cnt - icnt), 32'd0);

    // flush during a sw: all bytes still written, no reply
    mcnt = mem_reply_cnt;
    base = wr_a.size();
    start_mem(1'b1, 32'h204, 2'd2, 32'h01020304);
    tick();
    flush_signal = 1'b1; mem_query_en = 1'b0;
    tick();
    flush_signal = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("swflush_no_reply", 32'(mem_reply_cnt - mcnt), 32'd0);
    check("swflush_nwrites", 32'(wr_a.size() - base), 32'd4);
    if (wr_a.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("swflush_a%0d", i), wr_a[base+i], 32'h204 + 32'(i));
        check($sformatf("swflush_d%0d", i), 32'(wr_d[base+i]), 32'(4 - i));
      end
    end

    // rdy_in low for two cycles in the middle of a lw
    start_mem(1'b0, 32'h100, 2'd2, 32'h0);
    tick();
    rdy_in = 1'b0;
    tick(); tick();
    rdy_in = 1'b1;
    wait_reply(1'b0, 20, lat);
    check("rdy_latency", 32'(lat + 3), 32'd7);
    check("rdy_data", mem_reply_data, 32'h44332211);
    mem_query_en = 1'b0;
    tick();

    // async reset in the middle of a lw
    mcnt = mem_reply_cnt;
    start_mem(1'b0, 32'h100, 2'd2, 32'h0);
    tick(); tick();
    rst_in = 1'b0;
    #1;
    check("arst_mem_a", mem_a, 32'h0);
    check("arst_mem_wr", 32'(mem_wr), 32'h0);
    check("arst_reply_en", 32'({mem_reply_en, if_reply_en}), 32'h0);
    check("arst_mem_reply_data", mem_reply_data, 32'h0);
    check("arst_if_reply_data", if_reply_data, 32'h0);
    mem_query_en = 1'b0;
    tick();
    rst_in = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("arst_no_reply", 32'(mem_reply_cnt - mcnt), 32'd0);
    check("arst_idle_addr", mem_a, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_controller.md
Name: mem_controller

Overview:
- Responder for the LSB memory-query interface and for an instruction-fetch query port.
- Serialises each request into byte accesses on the single byte-wide RAM/IO bus.
- Assembles read data little-endian and returns it with a one-cycle reply pulse.
- Sits between LSB/IFetch and the external RAM; it is the only driver of the RAM address and write-enable.

Parameters:
- IO_SEL, 2'b11: value of addr[17:16] that marks an IO address.
- IDLE, 0: state code.
- READING, 1: state code.
- WRITING, 2: state code.
- DONE, 3: state code.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  low = pause; all registers hold
- io_buffer_full  in  1  high = IO write must not be issued this cycle
- mem_din  in  8  RAM read byte; valid one cycle after its address
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- mem_query_en  in  1  LSB request; held high until reply seen
- mem_query_type  in  1  0 = read, 1 = write
- mem_query_addr  in  32  start byte address
- mem_data_width  in  2  0/1/2 = 1/2/4 bytes
- mem_query_data  in  32  store data; low bytes used
- mem_reply_en  out  1  one-cycle done pulse to LSB
- mem_reply_data  out  32  read result, zero-extended raw bytes
- if_query_en  in  1  fetch request; held until reply
- if_query_addr  in  32  fetch address; always 4 bytes
- if_reply_en  out  1  one-cycle done pulse to IFetch
- if_reply_data  out  32  instruction word
- flush_signal  in  1  RoB flush

Behaviour:
- Reset (rst_in=0, async): state=IDLE. mem_a=0, mem_wr=0, mem_dout=0. Both reply_en=0, both reply_data=0. Byte counter=0.
- Priority: rst_in > !rdy_in (full hold; mem_wr keeps its value) > flush > normal.
- IDLE, sampling at an edge:
  - mem_query_en=1 wins over if_query_en=1.
  - Latch port, type, addr, N = 1<<width (width 3 treated as 4), and data.
  - Read: mem_a=addr, mem_wr=0, go READING.
  - Write: mem_a=addr, mem_dout=data[7:0], mem_wr=1, go WRITING.
- READING:
  - Issue addresses addr..addr+N-1 on consecutive cycles.
  - Capture mem_din into byte k (bits 8k+7:8k) one cycle after address k.
  - mem_a keeps incrementing only while issued count < N.
  - On capturing byte N-1: drive the port's reply_data (unused bytes 0) and reply_en=1, go DONE.
  - Latency: reply_en high in cycle N+1 after the accept edge (lw and fetch: 5; lb: 2).
- WRITING:
  - One byte per cycle; mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1.
  - Before issuing any byte with addr[17:16]==IO_SEL while io_buffer_full=1: mem_wr=0, hold k, retry next cycle.
  - After byte N-1 is written: mem_wr=0, reply_en=1 for the LSB, go DONE. Unstalled latency: N cycles.
- DONE:
  - Clear reply_en, go IDLE. Requests are not sampled in DONE; this covers the requester dropping its request one cycle after the reply.
- Address arithmetic: 32-bit wrap, no alignment check.
- mem_a is 0 and mem_wr is 0 whenever state is IDLE.
- Flush:
  - In READING or in DONE-after-read: abort; no reply pulse, reply_en=0, mem_wr=0, go IDLE.
  - In WRITING: the write is committed, so finish the remaining bytes; then go DONE but suppress reply_en.
  - In IDLE: requests are not accepted that cycle.
- A request arriving while busy is held by the requester; it is served in the first IDLE after DONE. Data port is still prioritised then.
- An async reset mid-operation drops the access immediately.

Decomposition:
- Shared package:
  - state codes.
  - width encoding (0/1/2).
  - IO_SEL.
  - query-type codes, shared with LSB.
- No sub-module is required. A byte-lane mux/assembler function may live in the package.

Test Plan:
- lw at 0x100 with RAM bytes 11,22,33,44 -> mem_reply_data=0x44332211, mem_reply_en high exactly cycle 5 after accept, for one cycle.
- sh at 0x200 with data 0xDEADBEEF -> writes EF@0x200 then BE@0x201, mem_wr high for 2 cycles; reply in cycle 2; RAM 0x202 untouched.
- mem_query_en and if_query_en both raised the same cycle -> data read served first. Fetch of 0x00000013 replied 1 cycle after the data reply's DONE plus 5 cycles. Neither request is served twice.
- sb to 0x30000 with io_buffer_full high 3 cycles -> mem_wr=0 for those 3 cycles, then one write of the low byte; reply 4 cycles after accept.
- Flush in cycle 2 of a fetch -> no if_reply_en, IDLE next cycle. Flush during a sw -> all 4 bytes still written, no reply.
- rst_in low in the middle of a lw -> all outputs 0 immediately, state IDLE. rdy_in low for 2 cycles mid-read -> latency +2, data correct.
